alu_result_encoder: RTL and testbench

Return-path counterpart of the ALU function decoder. It collects the four ALU unit result buses and their single-cycle done flags (Arith, Logic, CMP, Shift), encodes which unit fired back into the 2-bit function code (00/01/10/11), and registers the result. The registered result is presented on a valid/ready output port to the downstream writeback stage. The block also detects protocol violations: more than one unit firing at once, or a result arriving while the output is stalled.

---
 rtl/alu_result_encoder_if.sv | 45 ++++
 rtl/alu_result_encoder.sv | 135 +++++++++++++
 tb/tb_alu_result_encoder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_encoder_if
//  Purpose  : Bundle of ALU unit result buses, done flags, and the
//             valid/ready writeback port with error status.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_result_encoder_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] Arith_OUT;
  logic [WIDTH-1:0] Logic_OUT;
  logic [WIDTH-1:0] CMP_OUT;
  logic [WIDTH-1:0] Shift_OUT;
  logic             Arith_Flag;
  logic             Logic_Flag;
  logic             CMP_Flag;
  logic             Shift_Flag;
  logic             OUT_READY;
  logic             ERR_CLR;
  logic [WIDTH-1:0] ALU_OUT;
  logic [1:0]       Unit_Code;
  logic             OUT_VALID;
  logic             MULTI_ERR;
  logic             OVF_ERR;
  logic [CNT_W-1:0] ERR_CNT;

  // Producer side: the ALU units and the writeback stage driving the encoder.
  modport master (
    output Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
    output Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
    output OUT_READY, ERR_CLR,
    input  ALU_OUT, Unit_Code, OUT_VALID, MULTI_ERR, OVF_ERR, ERR_CNT
  );

  // Encoder side.
  modport slave (
    input  Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
    input  Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
    input  OUT_READY, ERR_CLR,
    output ALU_OUT, Unit_Code, OUT_VALID, MULTI_ERR, OVF_ERR, ERR_CNT
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_encoder
//  Purpose  : Collects the four ALU unit results, encodes the source unit,
//             registers the result onto a valid/ready port and flags
//             collisions and stalled-output overflows.
//  Revision : 1.0  initial release
// ============================================================================
module alu_result_encoder #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  alu_result_encoder_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           next_state;
  logic             capture;
  logic             multi;
  logic             ovf_evt;
  logic             err_evt;
  logic             load;
  logic [2:0]       flag_cnt;
  logic [WIDTH-1:0] sel_data;
  logic [1:0]       sel_code;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       code_q;
  logic             multi_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  // Fixed-priority select of the firing unit (Arith > Logic > CMP > Shift).
  always_comb begin
    sel_data = '0;
    sel_code = 2'b00;
    if (bus.Arith_Flag) begin
      sel_data = bus.Arith_OUT;
      sel_code = 2'b00;
    end else if (bus.Logic_Flag) begin
      sel_data = bus.Logic_OUT;
      sel_code = 2'b01;
    end else if (bus.CMP_Flag) begin
      sel_data = bus.CMP_OUT;
      sel_code = 2'b10;
    end else if (bus.Shift_Flag) begin
      sel_data = bus.Shift_OUT;
      sel_code = 2'b11;
    end
  end

  assign flag_cnt = {2'b00, bus.Arith_Flag} + {2'b00, bus.Logic_Flag}
                  + {2'b00, bus.CMP_Flag}   + {2'b00, bus.Shift_Flag};
  assign capture  = (flag_cnt != 3'd0);
  assign multi    = (flag_cnt > 3'd1);
  assign err_evt  = multi | ovf_evt;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next state, load enable and overflow detection; a drain with a
  // simultaneous capture reloads so back-to-back results see no bubble.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    ovf_evt    = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          load       = 1'b1;
          next_state = FULL;
        end
      end
      FULL: begin
        if (bus.OUT_READY) begin
          load       = capture;
          next_state = capture ? FULL : IDLE;
        end else begin
          ovf_evt = capture;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Result register; holds its value when drained or when a result is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q <= '0;
      code_q <= 2'b00;
    end else if (load) begin
      data_q <= sel_data;
      code_q <= sel_code;
    end
  end

  // Sticky errors and saturating counter; a clear takes effect before any
  // error recorded in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      multi_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.ERR_CLR) begin
      multi_q <= multi;
      ovf_q   <= ovf_evt;
      cnt_q   <= err_evt ? CNT_ONE : '0;
    end else begin
      multi_q <= multi_q | multi;
      ovf_q   <= ovf_q | ovf_evt;
      if (err_evt && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign bus.ALU_OUT   = data_q;
  assign bus.Unit_Code = code_q;
  assign bus.OUT_VALID = (state == FULL);
  assign bus.MULTI_ERR = multi_q;
  assign bus.OVF_ERR   = ovf_q;
  assign bus.ERR_CNT   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_encoder
//  Purpose  : Directed self-checking bench with a result scoreboard for
//             alu_result_encoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_result_encoder;

  logic CLK;
  logic RST;

  alu_result_encoder_if #(.WIDTH(16), .CNT_W(8)) bus ();

  alu_result_encoder #(.WIDTH(16), .CNT_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Expected {code, data} of each accepted result, in order.
  logic [17:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_flags();
    bus.Arith_Flag = 1'b0;
    bus.Logic_Flag = 1'b0;
    bus.CMP_Flag   = 1'b0;
    bus.Shift_Flag = 1'b0;
  endtask

  // Raise one unit's done flag with its data (other flags untouched).
  task automatic fire(input int unit, input logic [15:0] data);
    case (unit)
      0: begin bus.Arith_Flag = 1'b1; bus.Arith_OUT = data; end
      1: begin bus.Logic_Flag = 1'b1; bus.Logic_OUT = data; end
      2: begin bus.CMP_Flag   = 1'b1; bus.CMP_OUT   = data; end
      default: begin bus.Shift_Flag = 1'b1; bus.Shift_OUT = data; end
    endcase
  endtask

  task automatic push(input logic [1:0] code, input logic [15:0] data);
    sb_q.push_back({code, data});
  endtask

  // Advance one clock; a transfer happening on this edge is scored against
  // the oldest expected result. Returns 1 ns after the edge.
  task automatic tick();
    logic [17:0] exp;
    if (bus.OUT_VALID && bus.OUT_READY) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_xfer", {14'd0, bus.Unit_Code, bus.ALU_OUT}, 32'hFFFF_FFFF);
      end else begin
        exp = sb_q.pop_front();
        chk("sb_xfer", {14'd0, bus.Unit_Code, bus.ALU_OUT}, {14'd0, exp});
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [15:0] pulse_data[4];
    logic [15:0] cdata;
    pulse_data[0] = 16'h1357;
    pulse_data[1] = 16'hA5A5;
    pulse_data[2] = 16'h2468;
    pulse_data[3] = 16'hC3C3;

    RST = 1'b1;
    bus.OUT_READY = 1'b0;
    bus.ERR_CLR   = 1'b0;
    bus.Arith_OUT = '0;
    bus.Logic_OUT = '0;
    bus.CMP_OUT   = '0;
    bus.Shift_OUT = '0;
    clear_flags();

    // Reset state.
    #12;
    chk("rst_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("rst_data", {16'd0, bus.ALU_OUT}, 32'd0);
    chk("rst_code", {30'd0, bus.Unit_Code}, 32'd0);
    chk("rst_errs", {22'd0, bus.ERR_CNT, bus.MULTI_ERR, bus.OVF_ERR}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Single pulses from each unit, Logic first.
    bus.OUT_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int u;
      u = (k == 0) ? 1 : (k == 1) ? 0 : k;
      fire(u, pulse_data[u]);
      push(2'(u), pulse_data[u]);
      tick();
      clear_flags();
      chk("pulse_valid", {31'd0, bus.OUT_VALID}, 32'd1);
      chk("pulse_data", {16'd0, bus.ALU_OUT}, {16'd0, pulse_data[u]});
      chk("pulse_code", {30'd0, bus.Unit_Code}, u);
      tick();
      chk("pulse_one_cycle", {31'd0, bus.OUT_VALID}, 32'd0);
    end

    // Stall for five cycles, then drain.
    bus.OUT_READY = 1'b0;
    fire(0, 16'h0011);
    push(2'd0, 16'h0011);
    tick();
    clear_flags();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {31'd0, bus.OUT_VALID}, 32'd1);
      chk("stall_data", {16'd0, bus.ALU_OUT}, 32'h0011);
      tick();
    end
    bus.OUT_READY = 1'b1;
    tick();
    chk("drain_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("drain_no_err", {22'd0, bus.ERR_CNT, bus.MULTI_ERR, bus.OVF_ERR}, 32'd0);

    // Collision CMP + Shift: CMP wins.
    fire(2, 16'h0003);
    fire(3, 16'h0004);
    push(2'd2, 16'h0003);
    tick();
    clear_flags();
    chk("coll_code", {30'd0, bus.Unit_Code}, 32'd2);
    chk("coll_data", {16'd0, bus.ALU_OUT}, 32'h0003);
    chk("coll_multi", {31'd0, bus.MULTI_ERR}, 32'd1);
    chk("coll_ovf", {31'd0, bus.OVF_ERR}, 32'd0);
    chk("coll_cnt", {24'd0, bus.ERR_CNT}, 32'd1);
    tick();

    // Overflow: result dropped while stalled.
    bus.OUT_READY = 1'b0;
    fire(0, 16'h1234);
    push(2'd0, 16'h1234);
    tick();
    clear_flags();
    fire(3, 16'hBEEF);
    tick();
    clear_flags();
    chk("ovf_data_held", {16'd0, bus.ALU_OUT}, 32'h1234);
    chk("ovf_code_held", {30'd0, bus.Unit_Code}, 32'd0);
    chk("ovf_flag", {31'd0, bus.OVF_ERR}, 32'd1);
    chk("ovf_cnt", {24'd0, bus.ERR_CNT}, 32'd2);
    // Drain and reload in one cycle: no new error.
    bus.OUT_READY = 1'b1;
    fire(1, 16'h5678);
    push(2'd1, 16'h5678);
    tick();
    clear_flags();
    chk("reload_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    chk("reload_data", {16'd0, bus.ALU_OUT}, 32'h5678);
    chk("reload_code", {30'd0, bus.Unit_Code}, 32'd1);
    chk("reload_cnt", {24'd0, bus.ERR_CNT}, 32'd2);
    tick();
    chk("reload_drained", {31'd0, bus.OUT_VALID}, 32'd0);

    // 300 collision cycles at full throughput saturate the counter.
    for (int k = 0; k < 300; k++) begin
      cdata = 16'(k * 7 + 1);
      fire(0, cdata);
      fire(1, ~cdata);
      push(2'd0, cdata);
      tick();
    end
    clear_flags();
    chk("sat_cnt", {24'd0, bus.ERR_CNT}, 32'd255);
    tick();

    // Clear together with a collision: clear first, then record.
    bus.ERR_CLR = 1'b1;
    fire(0, 16'h0A0A);
    fire(2, 16'h0B0B);
    push(2'd0, 16'h0A0A);
    tick();
    clear_flags();
    bus.ERR_CLR = 1'b0;
    chk("clr_multi", {31'd0, bus.MULTI_ERR}, 32'd1);
    chk("clr_ovf", {31'd0, bus.OVF_ERR}, 32'd0);
    chk("clr_cnt", {24'd0, bus.ERR_CNT}, 32'd1);
    chk("clr_data", {16'd0, bus.ALU_OUT}, 32'h0A0A);
    tick();
    bus.ERR_CLR = 1'b1;
    tick();
    bus.ERR_CLR = 1'b0;
    chk("clr_only", {22'd0, bus.ERR_CNT, bus.MULTI_ERR, bus.OVF_ERR}, 32'd0);

    // Async reset while FULL with errors set.
    bus.OUT_READY = 1'b0;
    fire(3, 16'h7777);
    push(2'd3, 16'h7777);
    tick();
    clear_flags();
    fire(3, 16'h8888);
    tick();
    clear_flags();
    chk("pre_rst_ovf", {31'd0, bus.OVF_ERR}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("arst_data", {16'd0, bus.ALU_OUT}, 32'd0);
    chk("arst_code", {30'd0, bus.Unit_Code}, 32'd0);
    chk("arst_errs", {22'd0, bus.ERR_CNT, bus.MULTI_ERR, bus.OVF_ERR}, 32'd0);
    sb_q.delete();
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_rst_idle", {31'd0, bus.OUT_VALID}, 32'd0);
    bus.OUT_READY = 1'b1;
    fire(1, 16'h4321);
    push(2'd1, 16'h4321);
    tick();
    clear_flags();
    chk("post_rst_valid", {31'd0, bus.OUT_VALID}, 32'd1);
    chk("post_rst_data", {16'd0, bus.ALU_OUT}, 32'h4321);
    chk("post_rst_code", {30'd0, bus.Unit_Code}, 32'd1);
    chk("post_rst_cnt", {24'd0, bus.ERR_CNT}, 32'd0);
    tick();
    chk("post_rst_drained", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
